// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds the opcode values and the FSM state type.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared datapath: radix-2 shift-add multiply and restoring divide on unsigned magnitudes.
// The working register holds {acc/remainder, multiplier/quotient}; one step per enable.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] step_result
);

  logic [2*WIDTH-1:0] work_r;
  logic [WIDTH-1:0]   b_r;
  logic               is_div_r;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     diff_s;

  // Next working value for one iteration of the selected operation.
  always_comb begin
    mul_sum_s = {1'b0, work_r[2*WIDTH-1:WIDTH]} +
                (work_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    rem_sh_s  = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
    diff_s    = rem_sh_s - {1'b0, b_r};
    if (is_div_r) begin
      // Borrow in diff_s[WIDTH] means the divisor did not fit: restore.
      if (!diff_s[WIDTH]) begin
        step_result = {diff_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
      end else begin
        step_result = {rem_sh_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_result = {mul_sum_s, work_r[WIDTH-1:1]};
    end
  end

  // Working/divisor registers: load operands or advance one step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_r   <= {(2*WIDTH){1'b0}};
      b_r      <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
    end else if (load) begin
      work_r   <= {{WIDTH{1'b0}}, opa};
      b_r      <= opb;
      is_div_r <= is_div;
    end else if (step) begin
      work_r   <= step_result;
    end else begin
      work_r   <= work_r;
    end
  end

endmodule

// File: rtl/pipe_muldiv_unit.sv
// EXE-stage iterative MULT/MULTU/DIV/DIVU unit producing HI/LO, with pipeline stall and flush.
// Sign handling and the IDLE/RUN/FIN controller live here; the core works on magnitudes.
module pipe_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic                 neg_q_r;
  logic                 neg_r_r;
  logic                 is_div_r;
  logic                 is_signed_s;
  logic                 a_neg_s;
  logic                 b_neg_s;
  logic                 div0_s;
  logic                 accept_s;
  logic [WIDTH-1:0]     abs_a_s;
  logic [WIDTH-1:0]     abs_b_s;
  logic [2*WIDTH-1:0]   core_res_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     fin_hi_s;
  logic [WIDTH-1:0]     fin_lo_s;

  // Operand classification and magnitudes for the unsigned core.
  always_comb begin
    is_signed_s = (SIGNED_EN != 0) && (op[0] == 1'b0);
    a_neg_s     = is_signed_s & a[WIDTH-1];
    b_neg_s     = is_signed_s & b[WIDTH-1];
    abs_a_s     = a_neg_s ? (-a) : a;
    abs_b_s     = b_neg_s ? (-b) : b;
    div0_s      = op[1] & (b == {WIDTH{1'b0}});
    accept_s    = (state_r == ST_IDLE) & start & ~flush;
    stall       = accept_s | (state_r == ST_RUN);
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst         (rst),
    .load        (accept_s & ~div0_s),
    .step        ((state_r == ST_RUN) & ~flush),
    .is_div      (op[1]),
    .opa         (abs_a_s),
    .opb         (abs_b_s),
    .step_result (core_res_s)
  );

  // Sign fix-up of the final iteration's value; MIN/-1 wraps back to MIN naturally.
  always_comb begin
    prod_s = neg_q_r ? (-core_res_s) : core_res_s;
    if (is_div_r) begin
      fin_lo_s = neg_q_r ? (-core_res_s[WIDTH-1:0]) : core_res_s[WIDTH-1:0];
      fin_hi_s = neg_r_r ? (-core_res_s[2*WIDTH-1:WIDTH]) : core_res_s[2*WIDTH-1:WIDTH];
    end else begin
      fin_lo_s = prod_s[WIDTH-1:0];
      fin_hi_s = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Controller with registered busy/done/result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      is_div_r    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          if (accept_s) begin
            cnt_r    <= {CW{1'b0}};
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            is_div_r <= op[1];
            if (div0_s) begin
              state_r     <= ST_FIN;
              busy        <= 1'b0;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              hi          <= a;
              lo          <= {WIDTH{1'b1}};
            end else begin
              state_r <= ST_RUN;
              busy    <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= ST_FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            hi      <= fin_hi_s;
            lo      <= fin_lo_s;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_FIN: begin
          state_r     <= ST_IDLE;
          done        <= 1'b0;
          div_by_zero <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy        <= 1'b0;
          done        <= 1'b0;
          div_by_zero <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// Self-checking bench for pipe_muldiv_unit (WIDTH=32): directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_pipe_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, stall, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  pipe_muldiv_unit #(.WIDTH(W), .SIGNED_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: 64-bit integer arithmetic, division truncating toward zero.
  task automatic ref_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rz);
    longint sx, sy, p;
    longint unsigned ux, uy, up;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    rz = 1'b0;
    if (o[1] && y == '0) begin
      rh = x; rl = '1; rz = 1'b1;
    end else begin
      case (o)
        2'b00: begin p = sx * sy; rh = p[2*W-1:W]; rl = p[W-1:0]; end
        2'b01: begin up = ux * uy; rh = up[2*W-1:W]; rl = up[W-1:0]; end
        2'b10: begin p = sx / sy; rl = p[W-1:0]; p = sx % sy; rh = p[W-1:0]; end
        default: begin up = ux / uy; rl = up[W-1:0]; up = ux % uy; rh = up[W-1:0]; end
      endcase
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int flush_at, input bit poke);
    logic [W-1:0] rh, rl;
    logic rz;
    int n;
    bit seen, div0;
    ref_model(o, x, y, rh, rl, rz);
    div0 = o[1] && (y == '0);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    #1 check_eq("stall_issue", stall, 1);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    seen = 0;
    while (n < W + 10) begin
      if (done) begin
        seen = 1;
        break;
      end
      check_eq("busy_run", busy, 1);
      check_eq("stall_run", stall, 1);
      check_eq("hold_hi", hi, exp_hi);
      if (poke && n == 5) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      end
      if (n == flush_at) flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (flush) begin
        flush = 1'b0;
        check_eq("busy_flush", busy, 0);
        check_eq("hi_flush", hi, exp_hi);
        check_eq("lo_flush", lo, exp_lo);
        for (int k = 0; k < 4; k++) begin
          check_eq("done_flush", done, 0);
          @(posedge clk); #1;
        end
        check_eq("lo_after_flush", lo, exp_lo);
        return;
      end
      n++;
    end
    check_eq("done_seen", seen, 1);
    check_eq("latency", n, div0 ? 0 : W);
    check_eq("stall_fin", stall, 0);
    check_eq("busy_fin", busy, 0);
    check_eq("hi", hi, rh);
    check_eq("lo", lo, rl);
    check_eq("div_by_zero", div_by_zero, rz);
    exp_hi = rh;
    exp_lo = rl;
    @(posedge clk); #1;
    check_eq("done_pulse", done, 0);
    check_eq("busy_after", busy, 0);
    check_eq("dz_pulse", div_by_zero, 0);
    check_eq("lo_hold", lo, exp_lo);
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: pick_val = 32'h0000_0000;
      1: pick_val = 32'h8000_0000;
      2: pick_val = 32'hFFFF_FFFF;
      3: pick_val = 32'h0000_0001;
      default: pick_val = $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_dz", div_by_zero, 0);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    check_eq("rst_stall", stall, 0);
    @(negedge clk) rst = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0);
    check_eq("t1_hi", hi, 32'hFFFF_FFFE);
    check_eq("t1_lo", lo, 32'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, -1, 0);
    check_eq("t2_lo", lo, 32'hFFFF_FFF1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
    check_eq("t2_min_lo", lo, 32'h8000_0000);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, -1, 0);
    check_eq("t3_lo", lo, 32'hFFFF_FFFD);
    check_eq("t3_hi", hi, 32'hFFFF_FFFF);
    run_op(2'b11, 32'h0000_0007, 32'h0000_0002, -1, 0);
    run_op(2'b11, 32'h0000_0007, 32'h0000_0000, -1, 0);
    check_eq("t4_hi", hi, 32'h0000_0007);
    run_op(2'b10, 32'h8000_0000, 32'h0000_0000, -1, 0);

    run_op(2'b01, 32'd2, 32'd3, -1, 0);
    run_op(2'b11, 32'd100, 32'd7, 10, 0);
    check_eq("t5_lo", lo, 32'd6);
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
    #1 check_eq("stall_start_flush", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("idle_busy", busy, 0);
      check_eq("idle_done", done, 0);
      @(posedge clk); #1;
    end

    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 check_eq("busy_pre_rst", busy, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_hi", hi, 0);
    check_eq("arst_lo", lo, 0);
    check_eq("arst_done", done, 0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk) rst = 1'b1;
    run_op(2'b01, 32'd4, 32'd4, -1, 1);
    check_eq("t6_lo", lo, 32'd16);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick_val(), pick_val(), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, W-1)) : -1,
             ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
